// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register bank: register addresses and FSM states.
package spi_regs_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/spi_reg_bank.sv
// Commits each valid SPI write transaction once into five control registers,
// rejecting reads and out-of-range addresses into a saturating error counter.
module spi_reg_bank
  import spi_regs_pkg::*;
#(
  parameter logic [6:0] MAX_ADDR = 7'h04,
  parameter int         ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read_write,
  input  logic [6:0]       addr,
  input  logic [7:0]       data,
  input  logic             valid,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             wr_strobe,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic [7:0]       out_lo_q, out_lo_d;
  logic [7:0]       out_hi_q, out_hi_d;
  logic [7:0]       pwm_lo_q, pwm_lo_d;
  logic [7:0]       pwm_hi_q, pwm_hi_d;
  logic [7:0]       duty_q, duty_d;
  logic             strobe_q, strobe_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             accept, reject;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Reset lands in HOLD so a valid still high from before reset is ignored.
      state_q  <= HOLD;
      out_lo_q <= 8'h00;
      out_hi_q <= 8'h00;
      pwm_lo_q <= 8'h00;
      pwm_hi_q <= 8'h00;
      duty_q   <= 8'h00;
      strobe_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      pwm_lo_q <= pwm_lo_d;
      pwm_hi_q <= pwm_hi_d;
      duty_q   <= duty_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = HOLD;
          if (read_write && (addr <= MAX_ADDR)) accept = 1'b1;
          else                                  reject = 1'b1;
        end
      end
      HOLD: begin
        if (!valid) state_d = IDLE;
      end
      default: state_d = HOLD;
    endcase

    if (accept) begin
      case (addr)
        ADDR_EN_OUT_7_0:  out_lo_d = data;
        ADDR_EN_OUT_15_8: out_hi_d = data;
        ADDR_EN_PWM_7_0:  pwm_lo_d = data;
        ADDR_EN_PWM_15_8: pwm_hi_d = data;
        ADDR_PWM_DUTY:    duty_d   = data;
        default: ;
      endcase
    end

    // A transaction with both fault conditions still counts only once.
    if (reject && (err_q != ERR_MAX)) err_d = err_q + 1'b1;

    strobe_d = accept;
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_strobe       = strobe_q;
  assign err_count       = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios plus randomized
// transactions compared every cycle against a transaction-level model.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       read_write;
  logic [6:0] addr;
  logic [7:0] data;
  logic       valid;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;
  logic [3:0] err_count;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int strobe_cnt = 0;
  bit cmp_en = 1'b0;

  // Transaction-level model state.
  logic [7:0] m_regs [5];
  int         m_err;
  bit         m_strobe;
  bit         m_armed;

  spi_reg_bank #(.MAX_ADDR(7'h04), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .read_write(read_write), .addr(addr), .data(data),
    .valid(valid), .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // A transaction takes effect on the first clock where valid is high after
  // having been seen low since the previous commit or reset.
  always @(posedge clk) begin
    cycle++;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
      m_err = 0;
      m_strobe = 1'b0;
      m_armed = 1'b0;
    end else begin
      m_strobe = 1'b0;
      if (valid && m_armed) begin
        m_armed = 1'b0;
        if (read_write && addr <= 7'd4) begin
          m_regs[addr] = data;
          m_strobe = 1'b1;
        end else if (m_err < 15) begin
          m_err = m_err + 1;
        end
      end else if (!valid) begin
        m_armed = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      logic [47:0] act, exp;
      act = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
             pwm_duty_cycle, 3'b000, wr_strobe, err_count};
      exp = {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4],
             3'b000, m_strobe, m_err[3:0]};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL model_cycle%0d actual=%h required=%h", cycle, act, exp);
      end
      if (wr_strobe === 1'b1) strobe_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xact(input logic rw, input logic [6:0] a, input logic [7:0] d,
                      input int hold, input int gap);
    read_write = rw; addr = a; data = d; valid = 1'b1;
    tick(hold);
    valid = 1'b0;
    tick(gap);
  endtask

  initial begin
    logic [7:0] vals [5];
    rst_n = 1'b0; valid = 1'b0; read_write = 1'b0; addr = '0; data = '0;
    tick(2);
    cmp_en = 1'b1;
    check("reset_regs", {en_reg_out_7_0, en_reg_out_15_8, pwm_duty_cycle}, 32'h0);
    check("reset_err_strobe", {wr_strobe, err_count}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Single long write
    strobe_cnt = 0;
    xact(1'b1, 7'h00, 8'hA5, 40, 1);
    check("wr_a5_reg", en_reg_out_7_0, 8'hA5);
    check("wr_a5_model", m_regs[0], 8'hA5);
    check("wr_a5_others", {en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, 32'h0);
    check("wr_a5_strobes", strobe_cnt, 1);

    // Back-to-back writes
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h80;
    strobe_cnt = 0;
    for (int i = 0; i < 5; i++) xact(1'b1, 7'(i), vals[i], 3, 1);
    check("b2b_regs", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8}, 32'h11223344);
    check("b2b_duty", pwm_duty_cycle, 8'h80);
    check("b2b_strobes", strobe_cnt, 5);
    check("b2b_err", err_count, 4'h0);

    // Read and out-of-range write both rejected
    strobe_cnt = 0;
    xact(1'b0, 7'h04, 8'h5A, 3, 1);
    xact(1'b1, 7'h05, 8'hFF, 3, 1);
    check("rej_err", err_count, 4'h2);
    check("rej_strobes", strobe_cnt, 0);
    check("rej_regs", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8}, 32'h11223344);
    check("rej_duty", pwm_duty_cycle, 8'h80);

    // Saturation
    for (int i = 0; i < 20; i++) xact(i[0], 7'h7F, 8'h00, 2, 1);
    check("sat_err", err_count, 4'hF);
    xact(1'b0, 7'h00, 8'h00, 2, 1);
    check("sat_hold", err_count, 4'hF);
    check("sat_model", m_err, 15);

    // valid held across reset release is ignored
    rst_n = 1'b0; read_write = 1'b1; addr = 7'h04; data = 8'h7F; valid = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rst_held_duty", pwm_duty_cycle, 8'h00);
    check("rst_held_err", err_count, 4'h0);
    valid = 1'b0;
    tick(1);
    xact(1'b1, 7'h04, 8'h7F, 3, 1);
    check("rst_rewrite_duty", pwm_duty_cycle, 8'h7F);

    // Reset pulse while in HOLD
    read_write = 1'b1; addr = 7'h01; data = 8'h3C; valid = 1'b1;
    tick(2);
    check("hold_wr", en_reg_out_15_8, 8'h3C);
    rst_n = 1'b0;
    tick(1);
    check("hold_rst_regs", {en_reg_out_7_0, en_reg_out_15_8, pwm_duty_cycle}, 32'h0);
    check("hold_rst_err_strobe", {wr_strobe, err_count}, 32'h0);
    rst_n = 1'b1;
    tick(3);
    check("hold_rst_nocommit", en_reg_out_15_8, 8'h00);
    valid = 1'b0;
    tick(1);

    // Randomized traffic, occasional reset mid-transaction
    for (int t = 0; t < 400; t++) begin
      int h1, h2;
      read_write = ($urandom_range(9) < 7);
      addr = 7'($urandom_range(7));
      if ($urandom_range(15) == 0) addr = 7'($urandom_range(127));
      data = 8'($urandom);
      valid = 1'b1;
      h1 = $urandom_range(1, 4);
      h2 = $urandom_range(0, 3);
      tick(h1);
      if ($urandom_range(29) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick(h2);
      valid = 1'b0;
      tick($urandom_range(1, 3));
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
